// File: rtl/mcu_bus_arbiter_pkg.sv
// Shared types and constants for the three-way memory bus arbiter.
// Requester slots are ordered PPU, DMA, CPU in every packed per-requester bus.
package mcu_bus_arbiter_pkg;

    localparam int unsigned ADDR_W   = 16;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned NUM_REQ  = 3;
    localparam int unsigned STARVE_W = 8;
    localparam int unsigned LAT_W    = 3;

    localparam int unsigned REQ_PPU = 0;
    localparam int unsigned REQ_DMA = 1;
    localparam int unsigned REQ_CPU = 2;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_DONE   = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } bus_txn_t;

    // Mux the winning requester's write enable, address and data out of the flat buses
    function automatic bus_txn_t sel_txn(
        input logic [NUM_REQ-1:0]        onehot,
        input logic [NUM_REQ-1:0]        we,
        input logic [NUM_REQ*ADDR_W-1:0] addr,
        input logic [NUM_REQ*DATA_W-1:0] wdata
    );
        bus_txn_t txn;
        txn = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (onehot[i]) begin
                txn.we    = we[i];
                txn.addr  = addr[i*ADDR_W +: ADDR_W];
                txn.wdata = wdata[i*DATA_W +: DATA_W];
            end
        end
        return txn;
    endfunction

endpackage

// File: rtl/mcu_bus_arb_pick.sv
// Combinational winner selection: PPU first, then a locked DMA burst,
// then a starved CPU, then DMA, then CPU.
module mcu_bus_arb_pick
    import mcu_bus_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] iReq,
    input  logic               iDmaLock,
    input  logic               iStarve,
    output logic [NUM_REQ-1:0] oWinner_c
);

    always_comb begin
        oWinner_c = '0;
        if (iReq[REQ_PPU]) begin
            oWinner_c[REQ_PPU] = 1'b1;
        end else if (iDmaLock && iReq[REQ_DMA]) begin
            oWinner_c[REQ_DMA] = 1'b1;
        end else if (iStarve && iReq[REQ_CPU]) begin
            oWinner_c[REQ_CPU] = 1'b1;
        end else if (iReq[REQ_DMA]) begin
            oWinner_c[REQ_DMA] = 1'b1;
        end else if (iReq[REQ_CPU]) begin
            oWinner_c[REQ_CPU] = 1'b1;
        end
    end

endmodule

// File: rtl/mcu_bus_arbiter.sv
// Serialises PPU, OAM DMA and CPU accesses onto one memory bus.
// IDLE arbitrates, ACCESS holds strobes for MEM_LATENCY cycles, DONE pulses the ack.
module mcu_bus_arbiter
    import mcu_bus_arbiter_pkg::*;
#(
    parameter int unsigned MEM_LATENCY  = 1,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                      iClock,
    input  logic                      iReset_n,
    input  logic [NUM_REQ-1:0]        iReq,
    input  logic [NUM_REQ-1:0]        iWe,
    input  logic [NUM_REQ*ADDR_W-1:0] iAddr,
    input  logic [NUM_REQ*DATA_W-1:0] iWData,
    input  logic                      iDmaLock,
    output logic [NUM_REQ-1:0]        oGnt,
    output logic [NUM_REQ-1:0]        oAck,
    output logic [DATA_W-1:0]         oRData,
    output logic [ADDR_W-1:0]         oMemAddr,
    output logic [DATA_W-1:0]         oMemWData,
    output logic                      oMemWe,
    output logic                      oMemRe,
    input  logic [DATA_W-1:0]         iMemRData
);

    arb_state_e           r_state;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [NUM_REQ-1:0]   r_ack;
    logic [DATA_W-1:0]    r_rdata;
    logic [ADDR_W-1:0]    r_mem_addr;
    logic [DATA_W-1:0]    r_mem_wdata;
    logic                 r_mem_we;
    logic                 r_mem_re;
    logic [STARVE_W-1:0]  r_starve_cnt;
    logic [LAT_W-1:0]     r_lat_cnt;

    arb_state_e           w_state_nxt;
    logic [NUM_REQ-1:0]   w_gnt_nxt;
    logic [NUM_REQ-1:0]   w_ack_nxt;
    logic [DATA_W-1:0]    w_rdata_nxt;
    logic [ADDR_W-1:0]    w_mem_addr_nxt;
    logic [DATA_W-1:0]    w_mem_wdata_nxt;
    logic                 w_mem_we_nxt;
    logic                 w_mem_re_nxt;
    logic [STARVE_W-1:0]  w_starve_cnt_nxt;
    logic [LAT_W-1:0]     w_lat_cnt_nxt;

    logic [NUM_REQ-1:0]   w_winner;
    logic                 w_starve;
    logic                 w_last_access;
    bus_txn_t             w_txn;

    assign w_starve      = (r_starve_cnt == STARVE_W'(STARVE_LIMIT));
    assign w_last_access = (r_lat_cnt == LAT_W'(MEM_LATENCY - 1));
    assign w_txn         = sel_txn(w_winner, iWe, iAddr, iWData);

    mcu_bus_arb_pick u_pick (
        .iReq      (iReq),
        .iDmaLock  (iDmaLock),
        .iStarve   (w_starve),
        .oWinner_c (w_winner)
    );

    // Next-state and registered-output values
    always_comb begin
        w_state_nxt     = r_state;
        w_gnt_nxt       = r_gnt;
        w_ack_nxt       = '0;
        w_rdata_nxt     = r_rdata;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_mem_we_nxt    = r_mem_we;
        w_mem_re_nxt    = r_mem_re;
        w_lat_cnt_nxt   = r_lat_cnt;

        case (r_state)
            ARB_IDLE: begin
                if (|iReq) begin
                    w_gnt_nxt       = w_winner;
                    w_mem_addr_nxt  = w_txn.addr;
                    w_mem_wdata_nxt = w_txn.wdata;
                    w_mem_we_nxt    = w_txn.we;
                    w_mem_re_nxt    = ~w_txn.we;
                    w_lat_cnt_nxt   = '0;
                    w_state_nxt     = ARB_ACCESS;
                end
            end
            ARB_ACCESS: begin
                if (w_last_access) begin
                    if (r_mem_re) begin
                        w_rdata_nxt = iMemRData;
                    end
                    w_mem_we_nxt = 1'b0;
                    w_mem_re_nxt = 1'b0;
                    w_ack_nxt    = r_gnt;
                    w_state_nxt  = ARB_DONE;
                end else begin
                    w_lat_cnt_nxt = r_lat_cnt + LAT_W'(1);
                end
            end
            ARB_DONE: begin
                w_gnt_nxt   = '0;
                w_state_nxt = ARB_IDLE;
            end
            default: begin
                w_gnt_nxt    = '0;
                w_mem_we_nxt = 1'b0;
                w_mem_re_nxt = 1'b0;
                w_state_nxt  = ARB_IDLE;
            end
        endcase
    end

    // CPU wait counter: saturating, cleared on CPU grant or dropped CPU request
    always_comb begin
        w_starve_cnt_nxt = r_starve_cnt;
        if (!iReq[REQ_CPU]) begin
            w_starve_cnt_nxt = '0;
        end else if ((r_state == ARB_IDLE) && w_winner[REQ_CPU]) begin
            w_starve_cnt_nxt = '0;
        end else if (!r_gnt[REQ_CPU] && !w_starve) begin
            w_starve_cnt_nxt = r_starve_cnt + STARVE_W'(1);
        end
    end

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            r_state      <= ARB_IDLE;
            r_gnt        <= '0;
            r_ack        <= '0;
            r_rdata      <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_we     <= 1'b0;
            r_mem_re     <= 1'b0;
            r_starve_cnt <= '0;
            r_lat_cnt    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_gnt        <= w_gnt_nxt;
            r_ack        <= w_ack_nxt;
            r_rdata      <= w_rdata_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_re     <= w_mem_re_nxt;
            r_starve_cnt <= w_starve_cnt_nxt;
            r_lat_cnt    <= w_lat_cnt_nxt;
        end
    end

    assign oGnt      = r_gnt;
    assign oAck      = r_ack;
    assign oRData    = r_rdata;
    assign oMemAddr  = r_mem_addr;
    assign oMemWData = r_mem_wdata;
    assign oMemWe    = r_mem_we;
    assign oMemRe    = r_mem_re;

endmodule

// File: tb/tb_mcu_bus_arbiter.sv
// Scoreboard bench for mcu_bus_arbiter: requester agents, a transaction-level
// reference model feeding expectation queues, and a monitor that pops on DUT activity.
module tb_mcu_bus_arbiter;

    localparam int LAT   = 1;
    localparam int LIMIT = 8;
    localparam int LAT4  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, rst4_n;

    // Main DUT stimulus and observation
    logic [2:0]  a_req = '0;
    logic [2:0]  a_we  = '0;
    logic [15:0] a_addr  [3];
    logic [7:0]  a_wdata [3];
    logic        lock   = 1'b0;
    logic [7:0]  mem_rd = '0;
    logic [47:0] w_addr;
    logic [23:0] w_wdata;
    logic [2:0]  gnt, ack;
    logic [7:0]  rdata, mwdata;
    logic [15:0] maddr;
    logic        mwe, mre;

    assign w_addr  = {a_addr[2], a_addr[1], a_addr[0]};
    assign w_wdata = {a_wdata[2], a_wdata[1], a_wdata[0]};

    mcu_bus_arbiter #(.MEM_LATENCY(LAT), .STARVE_LIMIT(LIMIT)) u_dut (
        .iClock(clk), .iReset_n(rst_n), .iReq(a_req), .iWe(a_we), .iAddr(w_addr),
        .iWData(w_wdata), .iDmaLock(lock), .oGnt(gnt), .oAck(ack), .oRData(rdata),
        .oMemAddr(maddr), .oMemWData(mwdata), .oMemWe(mwe), .oMemRe(mre), .iMemRData(mem_rd)
    );

    // Second instance for the long-latency reset-abort scenario
    logic [2:0]  r4_req = '0;
    logic [47:0] r4_addr = '0;
    logic [7:0]  r4_mrd = '0;
    logic [2:0]  gnt4, ack4;
    logic [7:0]  rdata4, mwdata4;
    logic [15:0] maddr4;
    logic        mwe4, mre4;

    mcu_bus_arbiter #(.MEM_LATENCY(LAT4), .STARVE_LIMIT(LIMIT)) u_dut4 (
        .iClock(clk), .iReset_n(rst4_n), .iReq(r4_req), .iWe(3'b000), .iAddr(r4_addr),
        .iWData(24'h0), .iDmaLock(1'b0), .oGnt(gnt4), .oAck(ack4), .oRData(rdata4),
        .oMemAddr(maddr4), .oMemWData(mwdata4), .oMemWe(mwe4), .oMemRe(mre4), .iMemRData(r4_mrd)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- requester agents ----------------
    int          n_left  [3] = '{0, 0, 0};
    int          gap     [3] = '{0, 0, 0};
    int          gap_max [3] = '{0, 0, 0};
    bit          waiting [3] = '{0, 0, 0};
    bit          fix_en  [3] = '{0, 0, 0};
    logic [15:0] fix_addr[3];
    logic        fix_we  [3];
    logic [7:0]  fix_wd  [3];
    bit          scramble_en = 0;
    bit          rand_lock   = 0;
    bit          mem_fixed   = 0;
    logic [7:0]  mem_val     = '0;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (waiting[i]) begin
                if (ack[i]) begin
                    a_req[i]   = 1'b0;
                    waiting[i] = 0;
                    gap[i]     = (gap_max[i] > 0) ? int'($urandom_range(0, gap_max[i])) : 0;
                end else if (scramble_en && gnt[i] && $urandom_range(0, 3) == 0) begin
                    // latched fields must be immune to late changes and dropped requests
                    a_addr[i]  = 16'($urandom);
                    a_wdata[i] = 8'($urandom);
                    if ($urandom_range(0, 1) == 1) a_req[i] = 1'b0;
                end
            end else if (n_left[i] > 0) begin
                if (gap[i] > 0) begin
                    gap[i]--;
                end else begin
                    a_addr[i]  = fix_en[i] ? fix_addr[i] : 16'($urandom);
                    a_we[i]    = fix_en[i] ? fix_we[i]   : 1'($urandom_range(0, 1));
                    a_wdata[i] = fix_en[i] ? fix_wd[i]   : 8'($urandom);
                    a_req[i]   = 1'b1;
                    waiting[i] = 1;
                    n_left[i]--;
                end
            end
        end
        mem_rd = mem_fixed ? mem_val : 8'($urandom);
        if (rand_lock && $urandom_range(0, 3) == 0) lock = ~lock;
    end

    // ---------------- reference model ----------------
    typedef struct {
        int          owner;
        logic [15:0] addr;
        logic        we;
        logic [7:0]  wdata;
        int          start;
    } exp_t;

    exp_t       q_txn[$];
    logic [7:0] q_rd[$];
    int         cyc = 0;
    int         m_busy = 0;
    int         m_owner = 0;
    int         m_cnt = 0;
    int         m_win;
    logic       m_we = 1'b0;
    logic [7:0] m_last_rd = '0;
    exp_t       m_e;

    function automatic int pick(input logic [2:0] r, input logic lk, input bit starve);
        if (r[0]) return 0;
        if (lk && r[1]) return 1;
        if (r[2] && starve) return 2;
        if (r[1]) return 1;
        return 2;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_cnt = 0; m_last_rd = '0;
            q_txn.delete(); q_rd.delete();
        end else begin
            cyc++;
            m_win = -1;
            if (m_busy == 0 && a_req != 3'b000) m_win = pick(a_req, lock, m_cnt == LIMIT);
            if (!a_req[2]) m_cnt = 0;
            else if (m_win == 2) m_cnt = 0;
            else if (!(m_busy > 0 && m_owner == 2) && m_cnt < LIMIT) m_cnt++;
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 1) begin
                    if (!m_we) m_last_rd = mem_rd;
                    q_rd.push_back(m_last_rd);
                end
            end else if (m_win >= 0) begin
                m_owner   = m_win;
                m_we      = a_we[m_win];
                m_e.owner = m_win;
                m_e.addr  = a_addr[m_win];
                m_e.we    = a_we[m_win];
                m_e.wdata = a_wdata[m_win];
                m_e.start = cyc;
                q_txn.push_back(m_e);
                m_busy = LAT + 1;
            end
        end
    end

    // ---------------- monitor ----------------
    int dma_acks = 0;
    bit cpu_seen = 0;
    int dma_at_cpu = -1;
    exp_t       mon_e;
    logic [7:0] mon_rd;
    logic [2:0] mon_oh;
    logic       mon_win;

    always @(negedge clk) begin
        if (rst_n) begin
            if (ack[1]) dma_acks++;
            if (ack[2] && !cpu_seen) begin cpu_seen = 1; dma_at_cpu = dma_acks; end
            if (mre || mwe) begin
                if (q_txn.size() == 0) begin
                    check("strobe_unexpected", {mre, mwe}, 2'b00);
                end else begin
                    mon_e   = q_txn[0];
                    mon_oh  = 3'b001 << mon_e.owner;
                    mon_win = (cyc >= mon_e.start) && (cyc <= mon_e.start + LAT - 1);
                    check("strobe",
                          {gnt, maddr, mwe, mre, (mon_e.we ? mwdata : 8'h00), mon_win},
                          {mon_oh, mon_e.addr, mon_e.we, ~mon_e.we, (mon_e.we ? mon_e.wdata : 8'h00), 1'b1});
                end
            end
            if (ack != 3'b000) begin
                if (q_txn.size() == 0 || q_rd.size() == 0) begin
                    check("ack_unexpected", ack, 3'b000);
                end else begin
                    mon_e  = q_txn.pop_front();
                    mon_rd = q_rd.pop_front();
                    mon_oh = 3'b001 << mon_e.owner;
                    check("ack", {ack, rdata, gnt, mwe, mre, 16'(cyc)},
                          {mon_oh, mon_rd, mon_oh, 1'b0, 1'b0, 16'(mon_e.start + LAT)});
                end
            end
            if (!(mre || mwe) && ack == 3'b000)
                check("idle", {gnt, q_txn.size() != 0}, 4'b0000);
        end
    end

    // ---------------- sequencing ----------------
    function automatic bit all_done();
        for (int i = 0; i < 3; i++) if (n_left[i] > 0 || waiting[i]) return 0;
        return 1;
    endfunction

    task automatic run_phase(input string name, input int budget);
        int k = 0;
        while (k < budget) begin
            @(posedge clk);
            if (all_done()) break;
            k++;
        end
        if (k == budget) check({name, "_timeout"}, 1, 0);
        repeat (2) @(posedge clk);
    endtask

    task automatic setup(input int i, input int n, input int g0, input int gm);
        n_left[i] = n; gap[i] = g0; gap_max[i] = gm; fix_en[i] = 0;
    endtask

    int         k4;
    bit         got4, seen4;
    logic [15:0] addr_seen4;

    initial begin
        for (int i = 0; i < 3; i++) begin a_addr[i] = '0; a_wdata[i] = '0; end
        rst_n = 1'b0; rst4_n = 1'b0;

        // reset held with all three requesting
        @(posedge clk);
        for (int i = 0; i < 3; i++) setup(i, 1, 0, 0);
        repeat (3) @(negedge clk);
        check("reset_outputs", {gnt, ack, rdata, maddr, mwdata, mwe, mre}, '0);
        rst_n = 1'b1;
        @(negedge clk);
        check("first_grant", gnt, 3'b001);
        run_phase("reset_release", 200);

        // single CPU read
        setup(2, 1, 0, 0);
        fix_en[2] = 1; fix_addr[2] = 16'hC000; fix_we[2] = 1'b0; fix_wd[2] = 8'h00;
        mem_fixed = 1; mem_val = 8'h5A;
        run_phase("cpu_read", 200);
        check("cpu_read_data", rdata, 8'h5A);

        // single DMA write; read data register must not change
        mem_fixed = 0;
        setup(1, 1, 0, 0);
        fix_en[1] = 1; fix_addr[1] = 16'hFE10; fix_we[1] = 1'b1; fix_wd[1] = 8'h33;
        run_phase("dma_write", 200);
        check("write_keeps_rdata", rdata, 8'h5A);

        // starvation: back-to-back DMA without lock, CPU waiting
        dma_acks = 0; cpu_seen = 0; dma_at_cpu = -1;
        setup(1, 12, 0, 0); setup(2, 1, 0, 0);
        run_phase("starve", 500);
        check("starve_dma_before_cpu", dma_at_cpu, 3);

        // DMA burst lock with a PPU request arriving mid-burst
        dma_acks = 0; cpu_seen = 0; dma_at_cpu = -1;
        lock = 1'b1;
        setup(1, 8, 0, 0); setup(2, 1, 0, 0); setup(0, 1, 6, 0);
        run_phase("lock", 500);
        lock = 1'b0;
        check("lock_dma_before_cpu", dma_at_cpu, 8);

        // randomized traffic with lock toggling, late field changes and dropped requests
        scramble_en = 1; rand_lock = 1;
        for (int i = 0; i < 3; i++) setup(i, 40, int'($urandom_range(0, 3)), 3);
        run_phase("random", 5000);
        scramble_en = 0; rand_lock = 0; lock = 1'b0;
        check("queues_drained", {32'(q_txn.size()), 32'(q_rd.size())}, 64'h0);

        // reset during ACCESS cycle 2 on the long-latency instance
        @(negedge clk); rst4_n = 1'b1;
        @(negedge clk); r4_req = 3'b100; r4_addr = {16'h1234, 32'h0}; r4_mrd = 8'h77;
        @(posedge clk);
        @(posedge clk); #1;
        check("rst4_pre", {mre4, maddr4}, {1'b1, 16'h1234});
        rst4_n = 1'b0; #1;
        check("rst4_async", {gnt4, ack4, mre4, mwe4}, 8'h00);
        seen4 = 0;
        repeat (3) begin @(negedge clk); if (ack4 != 3'b000) seen4 = 1; end
        check("rst4_no_ack", seen4, 0);
        r4_addr = {16'h5678, 32'h0};
        rst4_n = 1'b1;
        k4 = 0; got4 = 0; addr_seen4 = '0;
        while (k4 < 20 && !got4) begin
            @(negedge clk);
            k4++;
            if (mre4) addr_seen4 = maddr4;
            if (ack4 != 3'b000) got4 = 1;
        end
        check("rst4_restart", {ack4, rdata4, addr_seen4, 8'(k4)},
              {3'b100, 8'h77, 16'h5678, 8'(LAT4 + 1)});
        r4_req = 3'b000;
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
